mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_if.sv | 41 ++++
 rtl/mem_arb_rr_arb2.sv | 22 ++
 rtl/mem_arb.sv | 123 ++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg -- shared types and constants for the two-requester memory arbiter.
//   state_t      : arbiter FSM encoding (IDLE, GNT_I, GNT_D)
//   TIMEOUT_DEF  : default maximum mem_rdy-low wait cycles (0 disables)
//   ERR_DATA_BIT : fill bit for the read data returned on a timed-out access
//   LAST_I/LAST_D: round-robin history values (who was served last)
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam int   TIMEOUT_DEF  = 15;
  localparam logic ERR_DATA_BIT = 1'b0;

  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if -- bundle of the fetch port, data port and memory port of mem_arb.
//   slave  : the arbiter's view (requests and memory response in, acks and memory strobes out)
//   master : the environment's view (requesters plus memory model)
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_rdy,
    input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mem_arb_rr_arb2.sv
// rr_arb2 -- two-way round-robin picker (combinational).
//   req[1:0] : eligible requests, bit 0 = fetch (I), bit 1 = data (D)
//   last     : requester served last (0 = I, 1 = D)
//   gnt[1:0] : one-hot winner, or zero when nothing is requested
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      // contention: the side not served last wins
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// mem_arb -- arbitrates an instruction-fetch port and a data port onto one
// single-outstanding memory port, with round-robin fairness and a wait timeout.
//   clk, rst : clock and asynchronous active-low reset
//   bus      : mem_arb_if.slave (fetch/data request ports and memory port)
// Parameters: AW/DW address/data width, TIMEOUT max mem_rdy-low cycles (0 = off).
//
// state | meaning
// IDLE  | no access in flight, picking the next eligible requester
// GNT_I | fetch access on the memory port, waiting for mem_rdy
// GNT_D | data access on the memory port, waiting for mem_rdy
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic      clk,
  input logic      rst,
  mem_arb_if.slave bus
);

  // the counter only has to reach TIMEOUT-1: the edge that would make it
  // TIMEOUT is the abort edge
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  logic          last;
  logic [CW-1:0] wait_cnt;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          i_ack_q, i_err_q, d_ack_q, d_err_q;
  logic [DW-1:0] i_rdata_q, d_rdata_q;
  logic [1:0]    elig, gnt;
  logic          timeout_hit;

  // a requester still holds req during its ack cycle; that request is stale
  assign elig = {bus.d_req & ~d_ack_q, bus.i_req & ~i_ack_q};

  rr_arb2 u_rr (
    .req  (elig),
    .last (last),
    .gnt  (gnt)
  );

  assign timeout_hit = (TIMEOUT > 0) && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last        <= LAST_D;
      wait_cnt    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_ack_q     <= 1'b0;
      i_err_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      i_err_q <= 1'b0;
      d_ack_q <= 1'b0;
      d_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt[0]) begin
            state       <= GNT_I;
            mem_en_q    <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            wait_cnt    <= '0;
          end else if (gnt[1]) begin
            state       <= GNT_D;
            mem_en_q    <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            wait_cnt    <= '0;
          end
        end
        GNT_I, GNT_D: begin
          // mem_rdy takes priority over a timeout on the same edge
          if (bus.mem_rdy || timeout_hit) begin
            state    <= IDLE;
            mem_en_q <= 1'b0;
            if (state == GNT_I) begin
              i_ack_q   <= 1'b1;
              i_err_q   <= ~bus.mem_rdy;
              i_rdata_q <= bus.mem_rdy ? bus.mem_rdata : {DW{ERR_DATA_BIT}};
              last      <= LAST_I;
            end else begin
              d_ack_q   <= 1'b1;
              d_err_q   <= ~bus.mem_rdy;
              d_rdata_q <= bus.mem_rdy ? bus.mem_rdata : {DW{ERR_DATA_BIT}};
              last      <= LAST_D;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.i_ack     = i_ack_q;
  assign bus.i_err     = i_err_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_err     = d_err_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule
